// File: rtl/pcp_oci_trace_buffer.sv
// Circular on-chip trace RAM for the Nios II debug path, with JTAG readback and preload.
// Optional build macro: PCP_TRC_STOP_ON_FULL_EN (capture stops once the RAM has been filled).
module pcp_oci_trace_buffer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_tracectrl,
    input  logic              take_action_tracemem_a,
    input  logic              take_action_tracemem_b,
    input  logic              take_no_action_tracemem_a,
    input  logic              trc_valid,
    input  logic [DATA_W-1:0] trc_data,
    output logic              trc_on,
    output logic [ADDR_W-1:0] trc_im_addr,
    output logic              trc_wrap,
    output logic              tracemem_on,
    output logic              tracemem_tw,
    output logic [DATA_W-1:0] tracemem_trcdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              trc_on_q, trc_on_d;
    logic              trc_wrap_q, trc_wrap_d;
    logic [ADDR_W-1:0] trc_im_addr_q, trc_im_addr_d;
    logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
    logic [DATA_W-1:0] tracemem_trcdata_q;

    logic              capture_en;
    logic              jtag_wr_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Only part of jdo carries meaning here; fold the rest away.
    logic unused_jdo;
    assign unused_jdo = ^jdo;

    always_comb begin
        capture_en = trc_on_q & trc_valid & ~take_action_tracectrl;
        // Capture needs trc_on=1 and JTAG writes need trc_on=0, so the two never collide.
        jtag_wr_en = ~take_action_tracemem_a & take_action_tracemem_b & ~trc_on_q;

        trc_on_d      = trc_on_q;
        trc_wrap_d    = trc_wrap_q;
        trc_im_addr_d = trc_im_addr_q;
        if (take_action_tracectrl) begin
            trc_on_d = jdo[4];
            if (jdo[3]) begin
                trc_im_addr_d = '0;
                trc_wrap_d    = 1'b0;
            end
        end else if (capture_en) begin
            trc_im_addr_d = trc_im_addr_q + 1'b1;
            if (trc_im_addr_q == LAST_ADDR) begin
                trc_wrap_d = 1'b1;
`ifdef PCP_TRC_STOP_ON_FULL_EN
                trc_on_d   = 1'b0;
`endif
            end
        end

        jtag_addr_d = jtag_addr_q;
        if (take_action_tracemem_a) begin
            jtag_addr_d = jdo[19 +: ADDR_W];
        end else if (take_action_tracemem_b || take_no_action_tracemem_a) begin
            jtag_addr_d = jtag_addr_q + 1'b1;
        end

        mem_we    = reset_n & (capture_en | jtag_wr_en);
        mem_waddr = capture_en ? trc_im_addr_q : jtag_addr_q;
        mem_wdata = capture_en ? trc_data : jdo[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trc_on_q      <= 1'b0;
            trc_wrap_q    <= 1'b0;
            trc_im_addr_q <= '0;
            jtag_addr_q   <= '0;
        end else begin
            trc_on_q      <= trc_on_d;
            trc_wrap_q    <= trc_wrap_d;
            trc_im_addr_q <= trc_im_addr_d;
            jtag_addr_q   <= jtag_addr_d;
        end
    end

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tracemem_trcdata_q <= '0;
        end else begin
            tracemem_trcdata_q <= mem_q[jtag_addr_q];
        end
    end

    assign trc_on           = trc_on_q;
    assign trc_wrap         = trc_wrap_q;
    assign trc_im_addr      = trc_im_addr_q;
    assign tracemem_on      = trc_on_q;
    assign tracemem_tw      = trc_wrap_q;
    assign tracemem_trcdata = tracemem_trcdata_q;

endmodule
